// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Burst counter increment that sticks at the configured limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] max_v);
        return (cnt >= max_v) ? max_v : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin chooser: on a tie the port that did not own last wins.
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_owner,
    output logic winner,
    output logic valid
);

    // Winner selection from requests and the last owner.
    always_comb begin
        winner = PORT_A;
        valid  = a_req | b_req;
        if (a_req && b_req) begin
            winner = (last_owner == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            winner = PORT_B;
        end else begin
            winner = PORT_A;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port (A) and a loader/debug port (B) onto one synchronous-read
// data memory with bounded bursts and per-port read-return routing.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    arb_state_t        r_state;
    logic [3:0]        r_cnt;
    logic              r_last;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_pick_winner;
    logic              w_pick_valid;
    logic [3:0]        w_cnt_inc;
    logic              w_sel_b;

    dmem_rr_pick u_pick (
        .a_req      (a_req),
        .b_req      (b_req),
        .last_owner (r_last),
        .winner     (w_pick_winner),
        .valid      (w_pick_valid)
    );

    assign a_gnt     = (r_state == ST_OWN_A) && a_req;
    assign b_gnt     = (r_state == ST_OWN_B) && b_req;
    assign w_cnt_inc = sat_inc(r_cnt, MAX_CNT);
    assign w_sel_b   = (r_state == ST_OWN_B);

    assign mem_addr  = w_sel_b ? b_addr  : a_addr;
    assign mem_wdata = w_sel_b ? b_wdata : a_wdata;
    assign mem_we    = (a_gnt && a_we) || (b_gnt && b_we);

    // Read data is live from memory in the return cycle, then held.
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign a_rdata   = r_a_rvalid ? mem_rdata : r_a_rdata;
    assign b_rdata   = r_b_rvalid ? mem_rdata : r_b_rdata;

    // Ownership FSM with burst counter and last-owner tracking.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_last  <= PORT_B;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 4'd0;
                    if (w_pick_valid) begin
                        r_state <= (w_pick_winner == PORT_B) ? ST_OWN_B : ST_OWN_A;
                        r_last  <= w_pick_winner;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OWN_A: begin
                    if (!a_req) begin
                        r_cnt <= 4'd0;
                        if (b_req) begin
                            r_state <= ST_OWN_B;
                            r_last  <= PORT_B;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if ((w_cnt_inc == MAX_CNT) && b_req) begin
                        r_state <= ST_OWN_B;
                        r_last  <= PORT_B;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_OWN_B: begin
                    if (!b_req) begin
                        r_cnt <= 4'd0;
                        if (a_req) begin
                            r_state <= ST_OWN_A;
                            r_last  <= PORT_A;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if ((w_cnt_inc == MAX_CNT) && a_req) begin
                        r_state <= ST_OWN_A;
                        r_last  <= PORT_A;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // One-deep read return pipeline per port, tagged by the issuing port.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= a_gnt && !a_we;
            r_b_rvalid <= b_gnt && !b_we;
            if (r_a_rvalid) begin
                r_a_rdata <= mem_rdata;
            end
            if (r_b_rvalid) begin
                r_b_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: grant table plus read-return scoreboard.
module tb_dmem_arbiter;

    logic        clock;
    logic        resetn;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] tbmem [0:255];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic a_req, a_we, b_req, b_we;
        logic e_a_gnt, e_b_gnt, e_mem_we;
    } vec_t;
    vec_t vecs [0:30];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clock(clock), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memory model.
    always @(posedge clock) begin
        if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= tbmem[mem_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push expected read data on each read beat, pop on rvalid.
    always @(negedge clock) begin
        if (!resetn) begin
            qa.delete();
            qb.delete();
        end else begin
            chk("gnt_exclusive", {31'd0, a_gnt && b_gnt}, 32'd0);
            if (a_rvalid) begin
                if (qa.size() == 0) chk("a_stray_rvalid", 32'd1, 32'd0);
                else chk("a_rdata_sb", a_rdata, qa.pop_front());
            end
            if (b_rvalid) begin
                if (qb.size() == 0) chk("b_stray_rvalid", 32'd1, 32'd0);
                else chk("b_rdata_sb", b_rdata, qb.pop_front());
            end
            if (a_req && a_gnt && !a_we) qa.push_back(tbmem[a_addr[7:0]]);
            if (b_req && b_gnt && !b_we) qb.push_back(tbmem[b_addr[7:0]]);
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_in();
        repeat (3) next_cycle();
        resetn = 1'b1;
    endtask

    function automatic vec_t mk(input logic [6:0] bits);
        return vec_t'(bits);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = 32'hC0DE_0000 | i;
        tbmem[8'h10] = 32'hDEAD_BEEF;
        a_addr = 32'h0; a_wdata = 32'h0; b_addr = 32'h0; b_wdata = 32'h0;
        // {a_req,a_we,b_req,b_we, e_a_gnt,e_b_gnt,e_mem_we}
        vecs[0] = mk(7'b1010_000);
        for (int i = 1; i <= 4; i++)  vecs[i] = mk(7'b1010_100);
        for (int i = 5; i <= 8; i++)  vecs[i] = mk(7'b1010_010);
        for (int i = 9; i <= 12; i++) vecs[i] = mk(7'b1110_101);
        vecs[13] = mk(7'b1010_010);
        vecs[14] = mk(7'b0000_000);
        vecs[15] = mk(7'b1000_000);
        for (int i = 16; i <= 21; i++) vecs[i] = mk(7'b1000_100);
        vecs[22] = mk(7'b1010_100);
        vecs[23] = mk(7'b1010_010);
        vecs[24] = mk(7'b0011_011);
        vecs[25] = mk(7'b0000_000);
        vecs[26] = mk(7'b1000_000);
        vecs[27] = mk(7'b1000_100);
        vecs[28] = mk(7'b0010_000);
        vecs[29] = mk(7'b0010_010);
        vecs[30] = mk(7'b0000_000);

        do_reset();
        @(negedge clock);
        chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();

        // Single A read of 0x10.
        a_req = 1'b1; a_addr = 32'h10;
        @(negedge clock);
        chk("rd_idle_gnt", {31'd0, a_gnt}, 32'd0);
        next_cycle();
        @(negedge clock);
        chk("rd_a_gnt", {31'd0, a_gnt}, 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        a_req = 1'b0;
        @(negedge clock);
        chk("rd_a_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("rd_a_rdata", a_rdata, 32'hDEAD_BEEF);
        chk("rd_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rd_b_gnt", {31'd0, b_gnt}, 32'd0);
        next_cycle();
        @(negedge clock);
        chk("rd_a_rvalid_off", {31'd0, a_rvalid}, 32'd0);
        chk("rd_a_rdata_hold", a_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // Burst table starting from a fresh reset.
        do_reset();
        a_addr = 32'h44; b_addr = 32'h88;
        for (int i = 0; i <= 30; i++) begin
            a_req = vecs[i].a_req; a_we = vecs[i].a_we;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we;
            a_wdata = 32'h1111_0000 + i;
            b_wdata = 32'h2222_0000 + i;
            @(negedge clock);
            chk($sformatf("tbl%0d_a_gnt", i), {31'd0, a_gnt}, {31'd0, vecs[i].e_a_gnt});
            chk($sformatf("tbl%0d_b_gnt", i), {31'd0, b_gnt}, {31'd0, vecs[i].e_b_gnt});
            chk($sformatf("tbl%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_mem_we});
            next_cycle();
        end
        idle_in();

        // B write to 0x20 while A idle, then A reads it back.
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h1234_5678;
        @(negedge clock);
        chk("wr_idle_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        @(negedge clock);
        chk("wr_b_gnt", {31'd0, b_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h20);
        chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        next_cycle();
        b_req = 1'b0; b_we = 1'b0;
        a_req = 1'b1; a_addr = 32'h20;
        @(negedge clock);
        chk("wr_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("wr_mem_we_off", {31'd0, mem_we}, 32'd0);
        next_cycle();
        @(negedge clock);
        chk("rb_a_gnt", {31'd0, a_gnt}, 32'd1);
        next_cycle();
        a_req = 1'b0;
        @(negedge clock);
        chk("rb_a_rdata", a_rdata, 32'h1234_5678);
        next_cycle();
        next_cycle();

        // Reset during OWN_B with a read in flight.
        b_req = 1'b1; b_addr = 32'h88;
        next_cycle();
        @(negedge clock);
        chk("mr_b_gnt", {31'd0, b_gnt}, 32'd1);
        next_cycle();
        resetn = 1'b0;
        #1;
        chk("mr_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("mr_b_gnt_rst", {31'd0, b_gnt}, 32'd0);
        chk("mr_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("mr_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("mr_a_rdata", a_rdata, 32'd0);
        chk("mr_b_rdata", b_rdata, 32'd0);
        chk("mr_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        resetn = 1'b1;
        a_req = 1'b1; a_addr = 32'h44;
        @(negedge clock);
        chk("mr_post_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        next_cycle();
        @(negedge clock);
        chk("mr_tie_a_gnt", {31'd0, a_gnt}, 32'd1);
        chk("mr_tie_b_gnt", {31'd0, b_gnt}, 32'd0);
        next_cycle();
        idle_in();
        repeat (3) next_cycle();
        chk("sb_qa_empty", qa.size(), 32'd0);
        chk("sb_qb_empty", qb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
